pipeline_hazard_ctrl: RTL

//  Sequencing controller for the 5-stage LEGv8 pipeline (fetch/iDecode/iExecute/iMemory/writeback).

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 47 ++++
 rtl/pipeline_hazard_ctrl_if.sv | 33 +++
 rtl/pipeline_hazard_ctrl_fwd.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_AW    = 5;
    localparam int CNT_W     = 16;
    localparam int DRAIN_CYC = 4;
    localparam int DRAIN_W   = $clog2(DRAIN_CYC);

    // XZR reads as zero, so it can never carry a real dependency.
    localparam logic [REG_AW-1:0] ZERO_REG = 5'd31;
    localparam logic [7:0]        WAIT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    typedef logic [1:0] fwd_sel_t;
    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b01;

    // Operand source select; the younger MEM-stage result wins over WB.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_AW-1:0] src,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd
    );
        if (mem_we && (mem_rd != ZERO_REG) && (mem_rd == src))
            return FWD_MEM;
        else if (wb_we && (wb_rd != ZERO_REG) && (wb_rd == src))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side hazard inputs and controller outputs.
// Latency: n/a (wiring only).
// Backpressure: n/a; master = pipeline datapath, slave = hazard controller.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic [REG_AW-1:0] id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
    logic              id_uses_rm, ex_mem_read, mem_reg_write, mem_access;
    logic              mem_pc_src, dmem_ready, wb_reg_write, halt_req;

    logic              pc_write, ifid_write, ifid_flush, idex_bubble;
    logic              exmem_flush, stage_hold, halted, err_timeout;
    logic [1:0]        fwd_a, fwd_b, state;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    modport master (
        output id_rn, id_rm, id_uses_rm, ex_rn, ex_rm, ex_mem_read, ex_rd,
               mem_reg_write, mem_rd, mem_access, mem_pc_src, dmem_ready,
               wb_reg_write, wb_rd, halt_req,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush,
               stage_hold, fwd_a, fwd_b, state, halted, err_timeout,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rm, ex_rn, ex_rm, ex_mem_read, ex_rd,
               mem_reg_write, mem_rd, mem_access, mem_pc_src, dmem_ready,
               wb_reg_write, wb_rd, halt_req,
        output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush,
               stage_hold, fwd_a, fwd_b, state, halted, err_timeout,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// EX-stage operand forwarding compare (purely combinational).
// Latency: 0 cycles.
// Backpressure: none.
// Ports: ex_rn/ex_rm EX sources, mem_*/wb_* producer stages, fwd_a/fwd_b selects.
module pipeline_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] ex_rn,
    input  logic [REG_AW-1:0] ex_rm,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    output fwd_sel_t          fwd_a,
    output fwd_sel_t          fwd_b
);
    assign fwd_a = fwd_select(ex_rn, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    assign fwd_b = fwd_select(ex_rm, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// LEGv8 5-stage sequencing: stalls, flushes, dmem waits, halt/drain, forwarding, perf counters.
// Latency: control outputs combinational in the same cycle; state/counters update on next posedge.
// Backpressure: dmem_ready low holds PC/IF/ID and freezes ID/EX..MEM/WB via stage_hold.
// Ports: clk, reset (sync, active-low), bus (slave modport of pipeline_hazard_ctrl_if).
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave bus
);
    state_t             state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [7:0]         wait_q, wait_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               stall_inc, flush_inc;
    logic               pc_write, ifid_write, ifid_flush, idex_bubble;
    logic               exmem_flush, stage_hold, halted;

    logic mem_wait, load_use;
    assign mem_wait = bus.mem_access & ~bus.dmem_ready;
    assign load_use = bus.ex_mem_read & (bus.ex_rd != ZERO_REG) &
                      ((bus.ex_rd == bus.id_rn) | (bus.id_uses_rm & (bus.ex_rd == bus.id_rm)));

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        wait_d      = wait_q;
        err_d       = err_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        stage_hold  = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    stage_hold = 1'b1;
                    stall_inc  = 1'b1;
                    state_d    = ST_MEM_WAIT;
                end else if (bus.mem_pc_src) begin
                    // The flush kills the decode instr, so any load-use stall is moot.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    exmem_flush = 1'b1;
                    flush_inc   = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                end else if (bus.halt_req) begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    drain_d    = DRAIN_W'(DRAIN_CYC - 1);
                    state_d    = ST_DRAIN;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    wait_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    stage_hold = 1'b1;
                    stall_inc  = 1'b1;
                    wait_d     = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
                    if (wait_q == WAIT_MAX)
                        err_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Fetch is already off; branches resolving now have nothing left to redirect.
                pc_write   = 1'b0;
                ifid_flush = 1'b1;
                if (mem_wait) begin
                    ifid_write = 1'b0;
                    stage_hold = 1'b1;
                end else if (drain_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_HALTED: begin
                halted     = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                if (!bus.halt_req)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // Reset lets the pipeline load freely regardless of the stale state.
        if (!reset) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            exmem_flush = 1'b0;
            stage_hold  = 1'b0;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            drain_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            if (stall_inc) stall_q <= sat_inc(stall_q);
            if (flush_inc) flush_q <= sat_inc(flush_q);
        end
    end

    pipeline_fwd_unit u_fwd (
        .ex_rn         (bus.ex_rn),
        .ex_rm         (bus.ex_rm),
        .mem_reg_write (bus.mem_reg_write),
        .mem_rd        (bus.mem_rd),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_rd         (bus.wb_rd),
        .fwd_a         (bus.fwd_a),
        .fwd_b         (bus.fwd_b)
    );

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.exmem_flush = exmem_flush;
    assign bus.stage_hold  = stage_hold;
    assign bus.halted      = halted;
    assign bus.state       = state_q;
    assign bus.err_timeout = err_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;
endmodule
